// File: rtl/gobang_move_ctrl_pkg.sv
// Shared constants, player/result codes, FSM states and cell-index helpers
// for the gobang move controller.
package gobang_move_ctrl_pkg;

  localparam int N     = 15;
  localparam int CELLS = N * N;

  localparam logic [7:0] CELL_COUNT = 8'(CELLS);

  localparam logic P_BLACK = 1'b0;
  localparam logic P_WHITE = 1'b1;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_BLACK = 2'b01;
  localparam logic [1:0] WIN_WHITE = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_e;

  // Worst case 15*15+15 = 240, so 8 bits hold every index without truncation.
  function automatic logic [7:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return ({4'b0000, row} * 8'(N)) + {4'b0000, col};
  endfunction

  // Indices beyond the board shift the bit out, giving an all-zero mask.
  function automatic logic [CELLS-1:0] cell_mask(input logic [7:0] idx);
    return {{(CELLS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/gobang_move_ctrl.sv
// Gobang game-state controller: validates and places moves, hands the mover's
// map to the external win checkers, registers the verdict and ends the game.
module gobang_move_ctrl
  import gobang_move_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [3:0]       move_row,
  input  logic [3:0]       move_col,
  output logic             move_ready,
  output logic             illegal,
  output logic             move_done,
  output logic             turn,
  output logic [CELLS-1:0] black_map,
  output logic [CELLS-1:0] white_map,
  output logic [3:0]       chk_row,
  output logic [3:0]       chk_col,
  output logic [CELLS-1:0] chk_map,
  input  logic             win_in,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [7:0]       move_count
);

  // Handshake: a move is taken on a rising edge where move_valid && move_ready;
  // move_ready is high only in IDLE, and move_valid elsewhere is ignored.

  state_e           state;
  state_e           state_next;
  logic [7:0]       idx;
  logic [CELLS-1:0] mask;
  logic             in_range;
  logic             occupied;
  logic             bad_move;
  logic             take;
  logic             board_full;

  assign in_range   = (move_row < 4'(N)) && (move_col < 4'(N));
  assign idx        = cell_idx(move_row, move_col);
  assign mask       = cell_mask(idx);
  assign occupied   = |((black_map | white_map) & mask);
  assign bad_move   = !in_range || occupied;
  assign take       = move_valid && move_ready;
  assign board_full = (move_count == CELL_COUNT);

  assign move_ready = (state == S_IDLE);
  assign game_over  = (state == S_OVER);
  // Turn is not toggled until CHECK completes, so this is always the mover's map.
  assign chk_map    = (turn == P_WHITE) ? white_map : black_map;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (take && !bad_move) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (win_in || board_full) state_next = S_OVER;
        else                      state_next = S_IDLE;
      end
      S_OVER: begin
        state_next = S_OVER;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (new_game) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      black_map  <= '0;
      white_map  <= '0;
      turn       <= P_BLACK;
      chk_row    <= '0;
      chk_col    <= '0;
      winner     <= WIN_NONE;
      move_count <= '0;
      illegal    <= 1'b0;
      move_done  <= 1'b0;
    end else if (new_game) begin
      black_map  <= '0;
      white_map  <= '0;
      turn       <= P_BLACK;
      chk_row    <= '0;
      chk_col    <= '0;
      winner     <= WIN_NONE;
      move_count <= '0;
      illegal    <= 1'b0;
      move_done  <= 1'b0;
    end else begin
      illegal   <= 1'b0;
      move_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            if (bad_move) begin
              illegal <= 1'b1;
            end else begin
              if (turn == P_WHITE) white_map <= white_map | mask;
              else                 black_map <= black_map | mask;
              chk_row <= move_row;
              chk_col <= move_col;
              if (!board_full) move_count <= move_count + 8'd1;
            end
          end
        end
        S_CHECK: begin
          move_done <= 1'b1;
          if (win_in) begin
            winner <= (turn == P_WHITE) ? WIN_WHITE : WIN_BLACK;
          end else if (board_full) begin
            winner <= WIN_DRAW;
          end else begin
            turn <= ~turn;
          end
        end
        default: begin
          // OVER holds everything for display until new_game.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gobang_move_ctrl.sv
// Directed and randomized bench for gobang_move_ctrl, checked against a
// 2-D board model with its own five-in-a-row checker driving win_in.
module tb_gobang_move_ctrl;

  localparam int NB = 15;
  localparam int NC = NB * NB;

  logic          clk;
  logic          rst;
  logic          new_game;
  logic          move_valid;
  logic [3:0]    move_row;
  logic [3:0]    move_col;
  logic          move_ready;
  logic          illegal;
  logic          move_done;
  logic          turn;
  logic [NC-1:0] black_map;
  logic [NC-1:0] white_map;
  logic [3:0]    chk_row;
  logic [3:0]    chk_col;
  logic [NC-1:0] chk_map;
  logic          win_in;
  logic          game_over;
  logic [1:0]    winner;
  logic [7:0]    move_count;

  gobang_move_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_row   (move_row),
    .move_col   (move_col),
    .move_ready (move_ready),
    .illegal    (illegal),
    .move_done  (move_done),
    .turn       (turn),
    .black_map  (black_map),
    .white_map  (white_map),
    .chk_row    (chk_row),
    .chk_col    (chk_col),
    .chk_map    (chk_map),
    .win_in     (win_in),
    .game_over  (game_over),
    .winner     (winner),
    .move_count (move_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: 0 empty, 1 black, 2 white
  int board[NB][NB];
  int m_turn;
  int m_count;
  int m_winner;
  bit m_over;
  bit win_en;
  int m_last_r;
  int m_last_c;

  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++)
        board[r][c] = 0;
    m_turn = 0; m_count = 0; m_winner = 0; m_over = 0;
    m_last_r = 0; m_last_c = 0;
  endtask

  function automatic logic [NC-1:0] exp_map(input int side);
    logic [NC-1:0] m;
    m = '0;
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++)
        if (board[r][c] == side) m[r*NB + c] = 1'b1;
    return m;
  endfunction

  function automatic bit five_from(input int r, input int c, input int side);
    int dr[4];
    int dc[4];
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int cnt;
      int rr;
      int cc;
      cnt = 1;
      rr = r + dr[d]; cc = c + dc[d];
      while (rr >= 0 && rr < NB && cc >= 0 && cc < NB && board[rr][cc] == side) begin
        cnt++; rr += dr[d]; cc += dc[d];
      end
      rr = r - dr[d]; cc = c - dc[d];
      while (rr >= 0 && rr < NB && cc >= 0 && cc < NB && board[rr][cc] == side) begin
        cnt++; rr -= dr[d]; cc -= dc[d];
      end
      if (cnt >= 5) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".black_map"},  black_map,  exp_map(1));
    chk({tag, ".white_map"},  white_map,  exp_map(2));
    chk({tag, ".turn"},       turn,       m_turn);
    chk({tag, ".move_count"}, move_count, m_count);
    chk({tag, ".winner"},     winner,     m_winner);
    chk({tag, ".game_over"},  game_over,  m_over);
  endtask

  task automatic check_reset_values(input string tag);
    check_outputs(tag);
    chk({tag, ".chk_row"},    chk_row,    0);
    chk({tag, ".chk_col"},    chk_col,    0);
    chk({tag, ".illegal"},    illegal,    0);
    chk({tag, ".move_done"},  move_done,  0);
    chk({tag, ".move_ready"}, move_ready, 1);
  endtask

  // driver: one move request, checked through to its verdict
  task automatic do_move(input int r, input int c);
    bit bad;
    bit won;
    string t;
    t = $sformatf("mv(%0d,%0d)", r, c);
    @(negedge clk);
    chk({t, ".ready"},      move_ready, 1);
    chk({t, ".pre_ill"},    illegal,    0);
    chk({t, ".pre_done"},   move_done,  0);
    move_valid = 1'b1;
    move_row   = r[3:0];
    move_col   = c[3:0];
    bad = (r >= NB) || (c >= NB);
    if (!bad) bad = (board[r][c] != 0);
    @(negedge clk);
    move_valid = 1'b0;
    if (bad) begin
      chk({t, ".illegal"},  illegal,    1);
      chk({t, ".done0"},    move_done,  0);
      chk({t, ".ready_il"}, move_ready, 1);
      check_outputs({t, ".il"});
    end else begin
      board[r][c] = m_turn + 1;
      m_count++;
      m_last_r = r; m_last_c = c;
      chk({t, ".illegal0"}, illegal,    0);
      chk({t, ".done_t1"},  move_done,  0);
      chk({t, ".ready_ck"}, move_ready, 0);
      chk({t, ".chk_row"},  chk_row,    r);
      chk({t, ".chk_col"},  chk_col,    c);
      chk({t, ".chk_map"},  chk_map,    exp_map(m_turn + 1));
      check_outputs({t, ".t1"});
      won = five_from(r, c, m_turn + 1);
      win_in = win_en && won;
      @(negedge clk);
      win_in = 1'b0;
      if (win_en && won) begin
        m_winner = (m_turn == 1) ? 2 : 1;
        m_over = 1;
      end else if (m_count == NC) begin
        m_winner = 3;
        m_over = 1;
      end else begin
        m_turn = 1 - m_turn;
      end
      chk({t, ".done"},     move_done,  1);
      chk({t, ".ill_t2"},   illegal,    0);
      chk({t, ".ready_t2"}, move_ready, !m_over);
      check_outputs({t, ".t2"});
    end
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    check_reset_values("new_game");
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; new_game = 1'b0; move_valid = 1'b0;
    move_row = '0; move_col = '0; win_in = 1'b0; win_en = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // first move, repeat on occupied cell, out of range, corner
    do_move(7, 7);
    chk("first.bit112", black_map[112], 1);
    do_move(7, 7);
    do_move(15, 0);
    do_move(0, 15);
    do_move(14, 14);
    chk("corner.bit224", white_map[224], 1);

    // black wins along row 0
    do_new_game();
    for (int i = 0; i < 4; i++) begin
      do_move(0, i);
      do_move(5, i);
    end
    do_move(0, 4);
    chk("win.winner", winner, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      move_valid = 1'b1; move_row = 4'd10; move_col = 4'(i);
      chk("over.ready",   move_ready, 0);
      chk("over.illegal", illegal,    0);
      chk("over.done",    move_done,  0);
      chk("over.chk_row", chk_row,    0);
      chk("over.chk_col", chk_col,    4);
      chk("over.chk_map", chk_map,    exp_map(1));
      check_outputs("over");
    end
    move_valid = 1'b0;

    // new_game during CHECK, together with a fresh move request
    do_new_game();
    do_move(3, 3);
    @(negedge clk);
    move_valid = 1'b1; move_row = 4'd8; move_col = 4'd8;
    @(negedge clk);
    move_valid = 1'b1; move_row = 4'd9; move_col = 4'd9; new_game = 1'b1;
    @(negedge clk);
    move_valid = 1'b0; new_game = 1'b0;
    model_reset();
    check_reset_values("abort");
    @(negedge clk);
    chk("abort.done_late", move_done, 0);
    check_outputs("abort.late");

    // randomized play in a crowded region so collisions and wins occur
    win_en = 1'b1;
    for (int k = 0; k < 90; k++) begin
      if (m_over) begin
        do_new_game();
      end else begin
        int r;
        int c;
        r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(4, 8));
        c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(4, 8));
        do_move(r, c);
      end
    end

    // fill the board with no checker verdict: last stone is a draw
    do_new_game();
    win_en = 1'b0;
    for (int i = 0; i < NC; i++) do_move(i / NB, i % NB);
    chk("draw.winner", winner, 2'b11);
    chk("draw.count",  move_count, NC);
    win_en = 1'b1;

    // asynchronous reset in the middle of CHECK
    do_new_game();
    @(negedge clk);
    move_valid = 1'b1; move_row = 4'd3; move_col = 4'd3;
    @(negedge clk);
    move_valid = 1'b0;
    chk("rstmid.in_check", move_ready, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_values("rstmid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rstmid.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
